sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 171 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one sram-like master port between an instruction
// slave port and a data slave port. One transaction is in flight at a time;
// the arbiter walks IDLE -> (ADDR) -> DATA -> IDLE for each transfer.
//
// Parameters
//   DATA_FIRST : 1 = data port has fixed priority, 0 = round-robin
// Ports
//   clk, rst                     : rising-edge clock, async active-high reset
//   inst_req/wr/size/addr/wdata  : instruction slave request
//   inst_rdata/addr_ok/data_ok   : instruction slave response
//   data_req/wr/size/addr/wdata  : data slave request
//   data_rdata/addr_ok/data_ok   : data slave response
//   m_req/wr/size/addr/wdata     : shared master request
//   m_rdata/addr_ok/data_ok      : master response
module sram_arbiter #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  // instruction slave port
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  // data slave port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  // shared master port
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t state_reg, state_next;
  logic   owner_reg, owner_next;           // 0 = inst, 1 = data
  logic   last_grant_reg, last_grant_next; // 0 = inst, 1 = data

  logic        any_req;
  logic        winner;
  logic        sel;        // port whose fields are muxed onto the master
  logic        sel_req;
  logic        sel_wr;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        addr_ok_grant;
  logic        data_ok_grant;

  assign any_req = inst_req | data_req;

  // Winner of a fresh arbitration round. In round-robin mode a tie goes to
  // the port that was not granted last; a lone requester always wins.
  always_comb begin
    winner = data_req;
    if (!DATA_FIRST && inst_req && data_req) begin
      winner = ~last_grant_reg;
    end
  end

  // In IDLE the fields come from the winner being granted this cycle; in
  // ADDR they come from the latched owner so no switch happens mid-request.
  assign sel       = (state_reg == IDLE) ? winner : owner_reg;
  assign sel_req   = sel ? data_req   : inst_req;
  assign sel_wr    = sel ? data_wr    : inst_wr;
  assign sel_size  = sel ? data_size  : inst_size;
  assign sel_addr  = sel ? data_addr  : inst_addr;
  assign sel_wdata = sel ? data_wdata : inst_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    m_req           = 1'b0;
    m_wr            = 1'b0;
    m_size          = '0;
    m_addr          = '0;
    m_wdata         = '0;
    data_ok_grant   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (any_req) begin
          m_req           = 1'b1;
          m_wr            = sel_wr;
          m_size          = sel_size;
          m_addr          = sel_addr;
          m_wdata         = sel_wdata;
          owner_next      = winner;
          last_grant_next = winner;
          state_next      = m_addr_ok ? DATA : ADDR;
        end
      end
      ADDR: begin
        // An owner that drops req before acceptance simply stalls here.
        if (sel_req) begin
          m_req   = 1'b1;
          m_wr    = sel_wr;
          m_size  = sel_size;
          m_addr  = sel_addr;
          m_wdata = sel_wdata;
          if (m_addr_ok) begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (m_data_ok) begin
          data_ok_grant = 1'b1;
          state_next    = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Outputs are forced low for as long as reset is held, not just from the
    // next edge, so a reset mid-transfer is visible to the slaves at once.
    if (rst) begin
      m_req         = 1'b0;
      m_wr          = 1'b0;
      m_size        = '0;
      m_addr        = '0;
      m_wdata       = '0;
      data_ok_grant = 1'b0;
    end
  end

  // m_req is only ever high in IDLE or ADDR, so this also restricts addr_ok
  // to those states.
  assign addr_ok_grant = m_req & m_addr_ok;

  assign inst_addr_ok = addr_ok_grant & ~sel;
  assign data_addr_ok = addr_ok_grant &  sel;
  assign inst_data_ok = data_ok_grant & ~owner_reg;
  assign data_data_ok = data_ok_grant &  owner_reg;

  // Read data is broadcast; data_ok is the only qualifier.
  assign inst_rdata = m_rdata;
  assign data_rdata = m_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter. Instance dut uses fixed data priority and is
// watched by a scoreboard monitor; instance dut_rr uses round-robin and is
// checked inline in its own scenario. Both share the input stimulus.
module tb_sram_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [31:0] m_rdata;
  logic        m_addr_ok, m_data_ok;

  logic [31:0] inst_rdata, data_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;

  logic [31:0] rr_inst_rdata, rr_data_rdata;
  logic        rr_inst_addr_ok, rr_inst_data_ok, rr_data_addr_ok, rr_data_data_ok;
  logic        rr_m_req, rr_m_wr;
  logic [1:0]  rr_m_size;
  logic [31:0] rr_m_addr, rr_m_wdata;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 0;

  typedef struct {
    bit          is_data;
    logic [31:0] addr;
    bit          wr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } grant_t;

  typedef struct {
    bit          is_data;
    logic [31:0] rdata;
  } resp_t;

  grant_t grant_q[$];
  resp_t  resp_q[$];

  sram_arbiter #(.DATA_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_addr_ok(m_addr_ok),
    .m_data_ok(m_data_ok)
  );

  sram_arbiter #(.DATA_FIRST(1'b0)) dut_rr (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(rr_inst_rdata),
    .inst_addr_ok(rr_inst_addr_ok), .inst_data_ok(rr_inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(rr_data_rdata),
    .data_addr_ok(rr_data_addr_ok), .data_data_ok(rr_data_data_ok),
    .m_req(rr_m_req), .m_wr(rr_m_wr), .m_size(rr_m_size), .m_addr(rr_m_addr),
    .m_wdata(rr_m_wdata), .m_rdata(m_rdata), .m_addr_ok(m_addr_ok),
    .m_data_ok(m_data_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every accepted master request and every slave
  // data_ok is matched against the queues filled when stimulus was driven.
  always begin
    @(negedge clk);
    #2;
    if (mon_en) begin
      if (m_req && m_addr_ok) begin
        n_tests++;
        if (grant_q.size() == 0) begin
          n_fail++;
          $display("FAIL grant_unexpected: got grant addr=%h, required none", m_addr);
        end else begin
          grant_t g;
          g = grant_q.pop_front();
          if (data_addr_ok !== g.is_data || inst_addr_ok !== !g.is_data ||
              m_addr !== g.addr || m_wr !== g.wr || m_size !== g.size ||
              m_wdata !== g.wdata) begin
            n_fail++;
            $display("FAIL grant: got d_aok=%b i_aok=%b addr=%h wr=%b size=%0d wdata=%h, required data=%b addr=%h wr=%b size=%0d wdata=%h",
                     data_addr_ok, inst_addr_ok, m_addr, m_wr, m_size, m_wdata,
                     g.is_data, g.addr, g.wr, g.size, g.wdata);
          end
          $display("[TB] grant %s addr=%h wr=%b", g.is_data ? "data" : "inst", g.addr, g.wr);
        end
      end
      if (inst_data_ok || data_data_ok) begin
        n_tests++;
        if (resp_q.size() == 0) begin
          n_fail++;
          $display("FAIL resp_unexpected: got i_dok=%b d_dok=%b, required none", inst_data_ok, data_data_ok);
        end else begin
          resp_t r;
          logic [31:0] got_rdata;
          r = resp_q.pop_front();
          got_rdata = r.is_data ? data_rdata : inst_rdata;
          if (data_data_ok !== r.is_data || inst_data_ok !== !r.is_data || got_rdata !== r.rdata) begin
            n_fail++;
            $display("FAIL resp: got d_dok=%b i_dok=%b rdata=%h, required data=%b rdata=%h",
                     data_data_ok, inst_data_ok, got_rdata, r.is_data, r.rdata);
          end
          $display("[TB] resp %s rdata=%h", r.is_data ? "data" : "inst", got_rdata);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = '0; inst_wdata = '0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = '0; data_wdata = '0;
    m_rdata = '0; m_addr_ok = 0; m_data_ok = 0;
  endtask

  task automatic do_reset();
    tick();
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    clear_inputs();
    tick();
    inst_req = 1; inst_addr = 32'hBFC00000; data_req = 1; data_wr = 1;
    data_addr = 32'h80000000; data_wdata = 32'hFFFFFFFF;
    m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'h12345678;
    #1;
    n_tests++;
    if ({m_req, m_wr, m_size, m_addr, m_wdata} !== 68'd0) begin
      n_fail++;
      $display("FAIL reset_master: got req=%b wr=%b size=%0d addr=%h wdata=%h, required all 0",
               m_req, m_wr, m_size, m_addr, m_wdata);
    end
    n_tests++;
    if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ok: got i_aok=%b d_aok=%b i_dok=%b d_dok=%b, required 0",
               inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok);
    end
    n_tests++;
    if (inst_rdata !== 32'h12345678 || data_rdata !== 32'h12345678) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h/%h, required 12345678", inst_rdata, data_rdata);
    end
    tick();
    clear_inputs();
    rst = 0;
    #1;
    n_tests++;
    if (m_req !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_noreq: got m_req=%b, required 0", m_req);
    end
    $display("[TB] reset checks done");
  endtask

  task automatic test_inst_read();
    tick();
    inst_req = 1; inst_wr = 0; inst_size = 2'd2; inst_addr = 32'hBFC00000; m_addr_ok = 1;
    grant_q.push_back('{0, 32'hBFC00000, 0, 2'd2, 32'h0});
    resp_q.push_back('{0, 32'h3C080001});
    #1;
    n_tests++;
    if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL inst_addr_ok: got i=%b d=%b, required 1/0", inst_addr_ok, data_addr_ok);
    end
    tick();
    inst_req = 0; m_addr_ok = 0;
    #1;
    n_tests++;
    if (m_req !== 1'b0) begin
      n_fail++;
      $display("FAIL data_state_req: got m_req=%b, required 0", m_req);
    end
    tick();
    m_data_ok = 1; m_rdata = 32'h3C080001;
    #1;
    n_tests++;
    if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h3C080001 || data_data_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL inst_read_resp: got i_dok=%b rdata=%h d_dok=%b, required 1/3c080001/0",
               inst_data_ok, inst_rdata, data_data_ok);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_priority();
    tick();
    inst_req = 1; inst_wr = 0; inst_size = 2'd2; inst_addr = 32'hBFC00004; inst_wdata = 32'h0;
    data_req = 1; data_wr = 1; data_size = 2'd2; data_addr = 32'h80001000; data_wdata = 32'hDEADBEEF;
    m_addr_ok = 1;
    grant_q.push_back('{1, 32'h80001000, 1, 2'd2, 32'hDEADBEEF});
    resp_q.push_back('{1, 32'h0});
    #1;
    n_tests++;
    if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0 || m_addr !== 32'h80001000) begin
      n_fail++;
      $display("FAIL prio_data_first: got d_aok=%b i_aok=%b addr=%h, required 1/0/80001000",
               data_addr_ok, inst_addr_ok, m_addr);
    end
    tick();
    data_req = 0; m_addr_ok = 0;
    #1;
    n_tests++;
    if (m_req !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_outstanding: got m_req=%b, required 0", m_req);
    end
    tick();
    m_data_ok = 1; m_rdata = 32'h0;
    #1;
    n_tests++;
    if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0 || m_req !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_write_ack: got d_dok=%b i_dok=%b m_req=%b, required 1/0/0",
               data_data_ok, inst_data_ok, m_req);
    end
    tick();
    m_data_ok = 0; m_addr_ok = 1;
    grant_q.push_back('{0, 32'hBFC00004, 0, 2'd2, 32'h0});
    resp_q.push_back('{0, 32'h24020005});
    #1;
    n_tests++;
    if (m_req !== 1'b1 || inst_addr_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL back_to_back: got m_req=%b i_aok=%b, required 1/1", m_req, inst_addr_ok);
    end
    tick();
    inst_req = 0; m_addr_ok = 0;
    tick();
    m_data_ok = 1; m_rdata = 32'h24020005;
    #1;
    n_tests++;
    if (inst_data_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_inst_resp: got i_dok=%b, required 1", inst_data_ok);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_addr_stall();
    tick();
    inst_req = 1; inst_addr = 32'hBFC00008;
    data_req = 1; data_wr = 0; data_size = 2'd0; data_addr = 32'h80002000; data_wdata = 32'h11112222;
    m_addr_ok = 0;
    #1;
    n_tests++;
    if (m_addr !== 32'h80002000 || data_addr_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_start: got addr=%h d_aok=%b, required 80002000/0", m_addr, data_addr_ok);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      data_addr = 32'h80002000 + 32'(i * 4);
      data_size = 2'(i);
      #1;
      n_tests++;
      if (m_req !== 1'b1 || m_addr !== data_addr || m_size !== data_size || inst_addr_ok !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_follow%0d: got req=%b addr=%h size=%0d i_aok=%b, required 1/%h/%0d/0",
                 i, m_req, m_addr, m_size, inst_addr_ok, data_addr, data_size);
      end
    end
    tick();
    data_req = 0; m_data_ok = 1;
    #1;
    n_tests++;
    if (m_req !== 1'b0 || data_data_ok !== 1'b0 || inst_data_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL addr_drop: got m_req=%b d_dok=%b i_dok=%b, required 0/0/0",
               m_req, data_data_ok, inst_data_ok);
    end
    tick();
    data_req = 1; data_addr = 32'h80002010; data_size = 2'd2; m_data_ok = 0; m_addr_ok = 1;
    grant_q.push_back('{1, 32'h80002010, 0, 2'd2, 32'h11112222});
    resp_q.push_back('{1, 32'hCAFEF00D});
    #1;
    n_tests++;
    if (data_addr_ok !== 1'b1 || m_addr !== 32'h80002010) begin
      n_fail++;
      $display("FAIL stall_accept: got d_aok=%b addr=%h, required 1/80002010", data_addr_ok, m_addr);
    end
    tick();
    data_req = 0; inst_req = 0; m_addr_ok = 0;
    tick();
    m_data_ok = 1; m_rdata = 32'hCAFEF00D;
    #1;
    n_tests++;
    if (data_data_ok !== 1'b1 || data_rdata !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL stall_resp: got d_dok=%b rdata=%h, required 1/cafef00d", data_data_ok, data_rdata);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_spurious_and_reset();
    tick();
    clear_inputs();
    m_data_ok = 1; m_rdata = 32'h55;
    #1;
    n_tests++;
    if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0 || m_req !== 1'b0) begin
      n_fail++;
      $display("FAIL spurious_idle: got i_dok=%b d_dok=%b m_req=%b, required 0", inst_data_ok, data_data_ok, m_req);
    end
    tick();
    m_data_ok = 0; inst_req = 1; inst_wr = 1; inst_addr = 32'h80003000; inst_wdata = 32'hA5A5A5A5;
    m_addr_ok = 1;
    grant_q.push_back('{0, 32'h80003000, 1, 2'd2, 32'hA5A5A5A5});
    tick();
    inst_req = 0; m_addr_ok = 0;
    #3;
    inst_req = 1; m_addr_ok = 1; m_data_ok = 1; rst = 1;
    #1;
    n_tests++;
    if ({m_req, m_wr, m_addr, m_wdata, inst_addr_ok, inst_data_ok, data_data_ok} !== 70'd0) begin
      n_fail++;
      $display("FAIL async_reset: got req=%b wr=%b addr=%h wdata=%h i_aok=%b i_dok=%b d_dok=%b, required 0",
               m_req, m_wr, m_addr, m_wdata, inst_addr_ok, inst_data_ok, data_data_ok);
    end
    tick();
    rst = 0; m_data_ok = 0; inst_wr = 0; inst_addr = 32'hBFC00010;
    grant_q.push_back('{0, 32'hBFC00010, 0, 2'd2, 32'hA5A5A5A5});
    resp_q.push_back('{0, 32'h77});
    #1;
    n_tests++;
    if (m_req !== 1'b1 || inst_addr_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_req: got m_req=%b i_aok=%b, required 1/1", m_req, inst_addr_ok);
    end
    tick();
    inst_req = 0; m_addr_ok = 0;
    tick();
    m_data_ok = 1; m_rdata = 32'h77;
    tick();
    clear_inputs();
  endtask

  task automatic test_round_robin();
    bit exp_order[$];
    bit last_owner;
    int grants;
    exp_order = '{0, 1, 0, 1};
    grants = 0;
    last_owner = 0;
    mon_en = 0;
    do_reset();
    inst_req = 1; inst_addr = 32'hBFC00020; data_req = 1; data_addr = 32'h80004000;
    m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'h0BADF00D;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (rr_inst_data_ok || rr_data_data_ok) begin
        n_tests++;
        if (rr_data_data_ok !== last_owner || rr_inst_data_ok !== !last_owner) begin
          n_fail++;
          $display("FAIL rr_resp: got d_dok=%b i_dok=%b, required owner=%b", rr_data_data_ok, rr_inst_data_ok, last_owner);
        end
      end
      if (rr_m_req && m_addr_ok && exp_order.size() > 0) begin
        bit e;
        e = exp_order.pop_front();
        n_tests++;
        if (rr_data_addr_ok !== e || rr_inst_addr_ok !== !e ||
            rr_m_addr !== (e ? 32'h80004000 : 32'hBFC00020)) begin
          n_fail++;
          $display("FAIL rr_order%0d: got d_aok=%b i_aok=%b addr=%h, required data=%b",
                   grants, rr_data_addr_ok, rr_inst_addr_ok, rr_m_addr, e);
        end
        $display("[TB] rr grant %0d to %s", grants, rr_data_addr_ok ? "data" : "inst");
        last_owner = e;
        grants++;
      end
      tick();
    end
    n_tests++;
    if (grants != 4) begin
      n_fail++;
      $display("FAIL rr_count: got %0d grants, required 4", grants);
    end
    do_reset();
    mon_en = 1;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    mon_en = 1;
    test_inst_read();
    test_priority();
    test_addr_stall();
    test_spurious_and_reset();
    test_round_robin();
    tick();
    tick();
    n_tests++;
    if (grant_q.size() != 0 || resp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d grants %0d resps left, required 0/0", grant_q.size(), resp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
